rr_burst_scheduler: RTL and testbench

Round-robin burst scheduler that shares one downstream resource between NUM_REQ requesters. A winning requester holds the grant for up to BURST_LEN accepted beats, or until it drops its request. The rotating priority pointer then advances past it. The block sits between the requester-side arbitration logic and the shared resource's beat-accept (ack) handshake, and it extends the plain single-cycle round-robin arbiter with burst ownership.

---
 rtl/rr_burst_scheduler_if.sv | 23 ++
 rtl/rr_burst_scheduler.sv | 93 +++++++++
 tb/tb_rr_burst_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rr_burst_scheduler_if.sv
// Requester/resource handshake bundle for rr_burst_scheduler.
// The slave side is the scheduler; the master side drives requests and acks.
interface rr_burst_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
);
  logic [NUM_REQ-1:0]           req_i;
  logic                         ack_i;
  logic [NUM_REQ-1:0]           gnt_o;
  logic [$clog2(NUM_REQ)-1:0]   gnt_id_o;
  logic [$clog2(BURST_LEN)-1:0] beat_cnt_o;
  logic                         busy_o;

  modport master (
    output req_i, ack_i,
    input  gnt_o, gnt_id_o, beat_cnt_o, busy_o
  );

  modport slave (
    input  req_i, ack_i,
    output gnt_o, gnt_id_o, beat_cnt_o, busy_o
  );
endinterface

// File: rtl/rr_burst_scheduler.sv
// Round-robin arbiter with burst ownership: a winner keeps the grant for up to
// BURST_LEN acked beats or until it drops req, then priority rotates past it.
module rr_burst_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input logic              clk,
  input logic              reset,
  rr_burst_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      id_q, id_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               rel;
  logic [IW-1:0]      nxt_ptr, arb_ptr, win_id;
  logic               win_vld;

  // Drop takes precedence over ack; either way the pointer moves past the owner.
  assign rel     = (state_q == GRANT) &&
                   (!bus.req_i[id_q] || (bus.ack_i && cnt_q == LAST_BEAT));
  assign nxt_ptr = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
  assign arb_ptr = rel ? nxt_ptr : ptr_q;

  // Scan from the highest offset down so the lowest offset from arb_ptr wins.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(arb_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.req_i[j]) begin
        win_vld = 1'b1;
        win_id  = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE || rel) begin
      ptr_d = arb_ptr;
      cnt_d = '0;
      if (win_vld) begin
        state_d        = GRANT;
        id_d           = win_id;
        gnt_d          = '0;
        gnt_d[win_id]  = 1'b1;
      end else begin
        state_d = IDLE;
        id_d    = '0;
        gnt_d   = '0;
      end
    end else if (bus.ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.gnt_id_o   = id_q;
  assign bus.beat_cnt_o = cnt_q;
  assign bus.busy_o     = (state_q == GRANT);
endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler with hand-computed expectations.
module tb_rr_burst_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  rr_burst_scheduler_if #(.NUM_REQ(4), .BURST_LEN(4)) bus ();
  rr_burst_scheduler #(.NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic [1:0] cnt, input logic busy);
    chk({tag, ".gnt"},  32'(bus.gnt_o),      32'(g));
    chk({tag, ".id"},   32'(bus.gnt_id_o),   32'(id));
    chk({tag, ".cnt"},  32'(bus.beat_cnt_o), 32'(cnt));
    chk({tag, ".busy"}, 32'(bus.busy_o),     32'(busy));
  endtask

  initial begin
    logic [3:0] g;
    // reset held with requests present
    reset = 1'b1;
    bus.req_i = 4'b1101;
    bus.ack_i = 1'b0;
    tick();
    tick();
    chk_all("rst_hold", 4'b0000, 2'd0, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("first_gnt", 4'b0001, 2'd0, 2'd0, 1'b1);

    // all requesting, ack every cycle: 4 beats each, no gaps
    bus.req_i = 4'b1111;
    bus.ack_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      g = 4'b0001 << ((k / 4) % 4);
      chk_all($sformatf("rr%0d", k), g, 2'((k / 4) % 4), 2'(k % 4), 1'b1);
    end

    // single requester 2: re-granted to itself with no bubble
    bus.req_i = 4'b0100;
    tick();
    chk_all("solo_start", 4'b0100, 2'd2, 2'd0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("solo%0d", k), 4'b0100, 2'd2, 2'(k % 4), 1'b1);
    end

    // requester 1 after two beats, then drop coinciding with ack
    bus.req_i = 4'b0010;
    bus.ack_i = 1'b0;
    tick();
    chk_all("drop_to1", 4'b0010, 2'd1, 2'd0, 1'b1);
    bus.ack_i = 1'b1;
    tick();
    tick();
    chk_all("two_beats", 4'b0010, 2'd1, 2'd2, 1'b1);
    bus.req_i = 4'b1001;
    tick();
    chk_all("drop_ack", 4'b1000, 2'd3, 2'd0, 1'b1);

    // long hold without ack; no timeout
    bus.req_i = 4'b0001;
    bus.ack_i = 1'b0;
    tick();
    chk_all("to0", 4'b0001, 2'd0, 2'd0, 1'b1);
    bus.req_i = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("hold%0d", k), 32'(bus.gnt_o), 32'h1);
    end
    chk_all("hold_end", 4'b0001, 2'd0, 2'd0, 1'b1);
    bus.ack_i = 1'b1;
    tick();
    chk_all("hold_ack", 4'b0001, 2'd0, 2'd1, 1'b1);

    // async reset mid-burst on requester 2 at beat 2
    bus.req_i = 4'b0100;
    bus.ack_i = 1'b0;
    tick();
    chk_all("to2", 4'b0100, 2'd2, 2'd0, 1'b1);
    bus.ack_i = 1'b1;
    tick();
    tick();
    chk_all("pre_rst", 4'b0100, 2'd2, 2'd2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 2'd0, 1'b0);
    bus.req_i = 4'b1111;
    bus.ack_i = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    chk_all("ptr_reset", 4'b0001, 2'd0, 2'd0, 1'b1);

    // release with nobody asking goes idle; ack in idle is ignored
    bus.req_i = 4'b0000;
    bus.ack_i = 1'b1;
    tick();
    chk_all("idle", 4'b0000, 2'd0, 2'd0, 1'b0);
    tick();
    chk_all("idle_ack", 4'b0000, 2'd0, 2'd0, 1'b0);
    bus.req_i = 4'b0101;
    bus.ack_i = 1'b0;
    tick();
    chk_all("idle_ptr", 4'b0100, 2'd2, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
